challenge_prober: RTL

//   Digital driver/measurer for the analog challenge cell. Drives its input (stim_out -> ua[0])

---
 rtl/challenge_prober.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/challenge_prober.sv
// challenge_prober: drives one step-up/step-down probe into the analog
// challenge cell and times its synchronised response in clk cycles.
module challenge_prober #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2,
    parameter int RESP_INV    = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_stim_out,
    input  logic             i_resp_in,
    output logic [CNT_W-1:0] o_rise_lat,
    output logic [CNT_W-1:0] o_fall_lat,
    output logic             o_timed_out,
    output logic             o_result_valid,
    input  logic             i_result_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_RISE,
        S_FALL,
        S_DONE
    } state_t;

    localparam logic             LP_INV  = (RESP_INV != 0);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_TMO  = CNT_W'(TIMEOUT);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_busy;
    logic                   r_stim;
    logic                   r_valid;
    logic                   r_timed_out;
    logic [CNT_W-1:0]       r_rise_lat;
    logic [CNT_W-1:0]       r_fall_lat;
    logic                   w_resp_s;

    // Bring the asynchronous cell response into the clk domain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_resp_in};
        end
    end

    assign w_resp_s = r_sync[SYNC_STAGES-1] ^ LP_INV;

    // Probe sequencer: every output is registered and set on the transition
    // into the state that owns it, so each state sees its values from cycle 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_stim      <= 1'b0;
            r_valid     <= 1'b0;
            r_timed_out <= 1'b0;
            r_rise_lat  <= '0;
            r_fall_lat  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!w_resp_s) begin
                        r_state <= S_RISE;
                        r_cnt   <= '0;
                        r_stim  <= 1'b1;
                    end else if (r_cnt == LP_LAST) begin
                        r_state     <= S_DONE;
                        r_cnt       <= '0;
                        r_valid     <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_rise_lat  <= '0;
                        r_fall_lat  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RISE: begin
                    if (w_resp_s) begin
                        r_state    <= S_FALL;
                        r_cnt      <= '0;
                        r_stim     <= 1'b0;
                        r_rise_lat <= r_cnt;
                    end else if (r_cnt == LP_LAST) begin
                        r_state     <= S_DONE;
                        r_cnt       <= '0;
                        r_stim      <= 1'b0;
                        r_valid     <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_rise_lat  <= LP_TMO;
                        r_fall_lat  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FALL: begin
                    if (!w_resp_s) begin
                        r_state     <= S_DONE;
                        r_cnt       <= '0;
                        r_valid     <= 1'b1;
                        r_timed_out <= 1'b0;
                        r_fall_lat  <= r_cnt;
                    end else if (r_cnt == LP_LAST) begin
                        r_state     <= S_DONE;
                        r_cnt       <= '0;
                        r_valid     <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_fall_lat  <= LP_TMO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_result_ready) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_stim  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_stim_out     = r_stim;
    assign o_result_valid = r_valid;
    assign o_timed_out    = r_timed_out;
    assign o_rise_lat     = r_rise_lat;
    assign o_fall_lat     = r_fall_lat;

endmodule
